// File: rtl/apb_timer_irq_ctrl.sv
// apb_timer_irq_ctrl: sticky, coalescing, maskable interrupt collector for APB timer pulses
module apb_timer_irq_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_IRQ          = 2,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_IRQ-1:0]          irq_i,
    output logic                      irq_o
);
    logic [5:0]           addr;
    logic                 access;
    logic                 wr;
    logic                 unused_ok;
    logic [N_IRQ-1:0]     pend_q, pend_d, mask_q, mask_d;
    logic [N_IRQ-1:0]     clr, set, fire, thr_wr;
    logic [CNT_WIDTH-1:0] thr_q  [N_IRQ];
    logic [CNT_WIDTH-1:0] thr_d  [N_IRQ];
    logic [CNT_WIDTH-1:0] acc_q  [N_IRQ];
    logic [CNT_WIDTH-1:0] acc_d  [N_IRQ];
    logic [CNT_WIDTH-1:0] miss_q [N_IRQ];
    logic [CNT_WIDTH-1:0] miss_d [N_IRQ];

    assign addr      = PADDR[5:0];
    assign access    = PSEL & PENABLE;
    assign wr        = access & PWRITE;
    assign PREADY    = access;
    assign PSLVERR   = 1'b0;
    assign irq_o     = |(pend_q & mask_q);
    assign unused_ok = ^{PADDR, PWDATA};

    // Next state: register writes, coalescing, sticky pending and saturating miss counters
    always_comb begin
        mask_d = (wr && addr == 6'h04) ? PWDATA[N_IRQ-1:0] : mask_q;
        clr    = (wr && addr == 6'h08) ? PWDATA[N_IRQ-1:0] : '0;
        set    = (wr && addr == 6'h0C) ? PWDATA[N_IRQ-1:0] : '0;
        for (int i = 0; i < N_IRQ; i++) begin
            thr_wr[i] = wr && addr == 6'(16 + 4 * i);
            fire[i]   = irq_i[i] && acc_q[i] == thr_q[i];
            thr_d[i]  = thr_wr[i] ? PWDATA[CNT_WIDTH-1:0] : thr_q[i];
            acc_d[i]  = (clr[i] || thr_wr[i] || fire[i]) ? '0 : irq_i[i] ? acc_q[i] + 1'b1 : acc_q[i];
            pend_d[i] = (fire[i] || set[i]) ? 1'b1 : clr[i] ? 1'b0 : pend_q[i];
            miss_d[i] = clr[i] ? '0 : (fire[i] && pend_q[i] && miss_q[i] != '1) ? miss_q[i] + 1'b1 : miss_q[i];
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q <= '0;
            mask_q <= '0;
            for (int i = 0; i < N_IRQ; i++) begin
                thr_q[i]  <= '0;
                acc_q[i]  <= '0;
                miss_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            for (int i = 0; i < N_IRQ; i++) begin
                thr_q[i]  <= thr_d[i];
                acc_q[i]  <= acc_d[i];
                miss_q[i] <= miss_d[i];
            end
        end
    end

    // Read mux: only during a read access phase, zero otherwise
    always_comb begin
        PRDATA = 32'h0;
        if (access && !PWRITE) begin
            if (addr == 6'h00) PRDATA[N_IRQ-1:0] = pend_q;
            if (addr == 6'h04) PRDATA[N_IRQ-1:0] = mask_q;
            for (int i = 0; i < N_IRQ; i++) begin
                if (addr == 6'(16 + 4 * i)) PRDATA[CNT_WIDTH-1:0] = thr_q[i];
                if (addr == 6'(32 + 4 * i)) PRDATA[CNT_WIDTH-1:0] = miss_q[i];
            end
        end
    end
endmodule
